bitwise_checker: RTL and testbench

BITWISE_CHECKER -- requirements
Module: bitwise_checker

---
 rtl/bitwise_pkg.sv | 21 ++
 rtl/bitwise_checker_if.sv | 35 +++
 rtl/bitwise_ref.sv | 17 +
 rtl/bitwise_checker.sv | 170 +++++++++++++++++
 tb/tb_bitwise_checker.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/bitwise_pkg.sv
// Shared constants for the bitwise operator checker: FSM encoding,
// fail_mask bit positions and default widths.
package bitwise_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 8;

    // fail_mask bit positions, one per operator
    localparam int MASK_AND = 0;
    localparam int MASK_NOT = 1;
    localparam int MASK_OR  = 2;
    localparam int MASK_XOR = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bitwise_checker_if.sv
// Run-control, sample and result bundle between a stimulus source (master)
// and the bitwise checker (slave).
interface bitwise_checker_if #(
    parameter int WIDTH = bitwise_pkg::DEFAULT_WIDTH,
    parameter int CNT_W = bitwise_pkg::DEFAULT_CNT_W
);
    logic             start;
    logic             end_run;
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_and;
    logic [WIDTH-1:0] in_not;
    logic [WIDTH-1:0] in_or;
    logic [WIDTH-1:0] in_xor;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             err;
    logic [3:0]       fail_mask;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;

    modport master (
        output start, end_run, in_valid, in_a, in_b, in_and, in_not, in_or, in_xor,
        input  in_ready, busy, done, pass_cnt, fail_cnt, err, fail_mask, fail_a, fail_b
    );

    modport slave (
        input  start, end_run, in_valid, in_a, in_b, in_and, in_not, in_or, in_xor,
        output in_ready, busy, done, pass_cnt, fail_cnt, err, fail_mask, fail_a, fail_b
    );
endinterface

// File: rtl/bitwise_ref.sv
// Golden model of the bitwise unit: purely combinational, reusable wherever
// reference AND/NOT/OR/XOR results are needed. NOT depends only on a.
module bitwise_ref #(
    parameter int WIDTH = bitwise_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_and,
    output logic [WIDTH-1:0] res_not,
    output logic [WIDTH-1:0] res_or,
    output logic [WIDTH-1:0] res_xor
);
    assign res_and = a & b;
    assign res_not = ~a;
    assign res_or  = a | b;
    assign res_xor = a ^ b;
endmodule

// File: rtl/bitwise_checker.sv
// Run-based checker for a bitwise unit: samples accepted in RUN are
// registered, compared against bitwise_ref one cycle later, and tallied in
// saturating pass/fail counters with first-failure capture.
module bitwise_checker
    import bitwise_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input logic               clk,
    input logic               rst,
    bitwise_checker_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_r;
    state_e           state_s;
    logic             accept_s;
    logic             run_enter_s;

    logic             smp_valid_r;
    logic [WIDTH-1:0] smp_a_r;
    logic [WIDTH-1:0] smp_b_r;
    logic [WIDTH-1:0] smp_and_r;
    logic [WIDTH-1:0] smp_not_r;
    logic [WIDTH-1:0] smp_or_r;
    logic [WIDTH-1:0] smp_xor_r;

    logic [WIDTH-1:0] ref_and_s;
    logic [WIDTH-1:0] ref_not_s;
    logic [WIDTH-1:0] ref_or_s;
    logic [WIDTH-1:0] ref_xor_s;
    logic [3:0]       mismatch_s;
    logic             smp_pass_s;

    logic             in_ready_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] pass_cnt_r;
    logic [CNT_W-1:0] fail_cnt_r;
    logic             err_r;
    logic [3:0]       fail_mask_r;
    logic [WIDTH-1:0] fail_a_r;
    logic [WIDTH-1:0] fail_b_r;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    bitwise_ref #(.WIDTH(WIDTH)) u_ref (
        .a       (smp_a_r),
        .b       (smp_b_r),
        .res_and (ref_and_s),
        .res_not (ref_not_s),
        .res_or  (ref_or_s),
        .res_xor (ref_xor_s)
    );

    // Next-state logic; stray start/end_run in other states fall through
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (bus.start)   state_s = ST_RUN;   else state_s = ST_IDLE;
            ST_RUN:   if (bus.end_run) state_s = ST_DRAIN; else state_s = ST_RUN;
            ST_DRAIN: state_s = ST_DONE;
            ST_DONE:  if (bus.start)   state_s = ST_RUN;   else state_s = ST_DONE;
            default:  state_s = ST_IDLE;
        endcase
    end

    assign accept_s    = bus.in_valid && in_ready_r;
    assign run_enter_s = (state_s == ST_RUN) && (state_r != ST_RUN);

    // Per-operator mismatch of the registered sample against the reference
    always_comb begin
        mismatch_s           = 4'b0000;
        mismatch_s[MASK_AND] = (smp_and_r != ref_and_s);
        mismatch_s[MASK_NOT] = (smp_not_r != ref_not_s);
        mismatch_s[MASK_OR]  = (smp_or_r  != ref_or_s);
        mismatch_s[MASK_XOR] = (smp_xor_r != ref_xor_s);
        smp_pass_s           = (mismatch_s == 4'b0000);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status flags registered from the next state so they line up with state_r
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= (state_s == ST_RUN);
            busy_r     <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
            done_r     <= (state_s == ST_DONE);
        end
    end

    // Sample register: holds an accepted sample for the compare stage
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_valid_r <= 1'b0;
            smp_a_r     <= '0;
            smp_b_r     <= '0;
            smp_and_r   <= '0;
            smp_not_r   <= '0;
            smp_or_r    <= '0;
            smp_xor_r   <= '0;
        end else if (accept_s) begin
            smp_valid_r <= 1'b1;
            smp_a_r     <= bus.in_a;
            smp_b_r     <= bus.in_b;
            smp_and_r   <= bus.in_and;
            smp_not_r   <= bus.in_not;
            smp_or_r    <= bus.in_or;
            smp_xor_r   <= bus.in_xor;
        end else begin
            smp_valid_r <= 1'b0;
        end
    end

    // Result tally: cleared on run entry, updated from the compare stage;
    // only the first failure of a run is captured
    always_ff @(posedge clk) begin
        if (rst || run_enter_s) begin
            pass_cnt_r  <= '0;
            fail_cnt_r  <= '0;
            err_r       <= 1'b0;
            fail_mask_r <= 4'b0000;
            fail_a_r    <= '0;
            fail_b_r    <= '0;
        end else if (smp_valid_r) begin
            if (smp_pass_s) begin
                pass_cnt_r <= sat_inc(pass_cnt_r);
            end else begin
                fail_cnt_r <= sat_inc(fail_cnt_r);
                err_r      <= 1'b1;
                if (!err_r) begin
                    fail_mask_r <= mismatch_s;
                    fail_a_r    <= smp_a_r;
                    fail_b_r    <= smp_b_r;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass_cnt  = pass_cnt_r;
    assign bus.fail_cnt  = fail_cnt_r;
    assign bus.err       = err_r;
    assign bus.fail_mask = fail_mask_r;
    assign bus.fail_a    = fail_a_r;
    assign bus.fail_b    = fail_b_r;

endmodule

// File: tb/tb_bitwise_checker.sv
// Directed self-checking bench for bitwise_checker. Inputs change and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_bitwise_checker;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bitwise_checker_if #(.WIDTH(4), .CNT_W(8)) bus ();

    bitwise_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_smp(input logic [3:0] a, input logic [3:0] b, input logic [3:0] y_and,
                           input logic [3:0] y_not, input logic [3:0] y_or, input logic [3:0] y_xor);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_and   = y_and;
        bus.in_not   = y_not;
        bus.in_or    = y_or;
        bus.in_xor   = y_xor;
    endtask

    task automatic clr_smp();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
        chk({tag, "_pass_cnt"},  32'(bus.pass_cnt),  32'd0);
        chk({tag, "_fail_cnt"},  32'(bus.fail_cnt),  32'd0);
        chk({tag, "_err"},       32'(bus.err),       32'd0);
        chk({tag, "_fail_mask"}, 32'(bus.fail_mask), 32'd0);
        chk({tag, "_fail_a"},    32'(bus.fail_a),    32'd0);
        chk({tag, "_fail_b"},    32'(bus.fail_b),    32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.end_run = 1'b0;
        set_smp(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        clr_smp();
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // in_valid in IDLE with a failing sample must not change anything
        set_smp(4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        clr_smp();
        chk_all_zero("idle_valid");

        // Run 1: single correct sample, then close the run
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("run1_in_ready", 32'(bus.in_ready), 32'd1);
        chk("run1_busy",     32'(bus.busy),     32'd1);
        set_smp(4'd12, 4'd5, 4'd4, 4'd3, 4'd13, 4'd9);
        tick();
        clr_smp();
        chk("run1_latency_pass", 32'(bus.pass_cnt), 32'd0);
        tick();
        chk("run1_pass_cnt", 32'(bus.pass_cnt), 32'd1);
        chk("run1_err",      32'(bus.err),      32'd0);
        bus.end_run = 1'b1; tick(); bus.end_run = 1'b0;
        chk("run1_drain_busy",  32'(bus.busy),     32'd1);
        chk("run1_drain_ready", 32'(bus.in_ready), 32'd0);
        chk("run1_drain_done",  32'(bus.done),     32'd0);
        tick();
        chk("run1_done",      32'(bus.done),     32'd1);
        chk("run1_done_busy", 32'(bus.busy),     32'd0);
        chk("run1_done_pass", 32'(bus.pass_cnt), 32'd1);

        // Run 2: two correct samples, end_run, done two cycles later
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("run2_cleared_pass", 32'(bus.pass_cnt), 32'd0);
        set_smp(4'd3, 4'd3, 4'd3, 4'd12, 4'd3, 4'd0); tick();
        set_smp(4'd0, 4'd1, 4'd0, 4'd15, 4'd1, 4'd1); tick();
        clr_smp();
        bus.end_run = 1'b1; tick(); bus.end_run = 1'b0;
        chk("run2_done_early", 32'(bus.done), 32'd0);
        bus.start = 1'b1; tick(); bus.start = 1'b0;   // start in DRAIN is ignored
        chk("run2_done",     32'(bus.done),     32'd1);
        chk("run2_pass_cnt", 32'(bus.pass_cnt), 32'd2);
        chk("run2_fail_cnt", 32'(bus.fail_cnt), 32'd0);
        bus.end_run = 1'b1;                             // end_run in DONE is ignored
        set_smp(4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);    // in_valid in DONE is ignored
        tick();
        bus.end_run = 1'b0;
        tick();
        clr_smp();
        chk("done_hold_done", 32'(bus.done),     32'd1);
        chk("done_hold_pass", 32'(bus.pass_cnt), 32'd2);
        chk("done_hold_fail", 32'(bus.fail_cnt), 32'd0);
        chk("done_hold_err",  32'(bus.err),      32'd0);

        // Run 3: two failures, only the first is captured
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        set_smp(4'd12, 4'd5, 4'd4, 4'd3, 4'd13, 4'd8); tick();
        set_smp(4'd3, 4'd3, 4'd3, 4'd12, 4'd0, 4'd0);  tick();
        clr_smp();
        tick();
        chk("run3_fail_cnt",  32'(bus.fail_cnt),  32'd2);
        chk("run3_pass_cnt",  32'(bus.pass_cnt),  32'd0);
        chk("run3_err",       32'(bus.err),       32'd1);
        chk("run3_fail_mask", 32'(bus.fail_mask), 32'd8);
        chk("run3_fail_a",    32'(bus.fail_a),    32'd12);
        chk("run3_fail_b",    32'(bus.fail_b),    32'd5);
        bus.start = 1'b1; tick(); bus.start = 1'b0;   // start in RUN is ignored
        chk("run3_start_in_run", 32'(bus.fail_cnt), 32'd2);
        bus.end_run = 1'b1; tick(); bus.end_run = 1'b0;
        tick();
        chk("run3_done", 32'(bus.done), 32'd1);

        // Run 4: 300 back-to-back correct samples saturate pass_cnt
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        set_smp(4'd12, 4'd5, 4'd4, 4'd3, 4'd13, 4'd9);
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        clr_smp();
        tick();
        chk("sat_pass_cnt", 32'(bus.pass_cnt), 32'd255);
        chk("sat_fail_cnt", 32'(bus.fail_cnt), 32'd0);
        bus.end_run = 1'b1; tick(); bus.end_run = 1'b0;
        tick();

        // Run 5: end_run coincides with a failing sample
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("run5_cleared_pass", 32'(bus.pass_cnt), 32'd0);
        set_smp(4'd0, 4'd1, 4'd1, 4'd15, 4'd1, 4'd1);
        bus.end_run = 1'b1;
        tick();
        clr_smp();
        bus.end_run = 1'b0;
        chk("run5_drain_done", 32'(bus.done), 32'd0);
        chk("run5_drain_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("run5_done",      32'(bus.done),      32'd1);
        chk("run5_fail_cnt",  32'(bus.fail_cnt),  32'd1);
        chk("run5_err",       32'(bus.err),       32'd1);
        chk("run5_pass_cnt",  32'(bus.pass_cnt),  32'd0);
        chk("run5_fail_mask", 32'(bus.fail_mask), 32'd1);
        chk("run5_fail_b",    32'(bus.fail_b),    32'd1);

        // Run 6: reset mid-run with a sample in flight, then a clean run
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        set_smp(4'd5, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        clr_smp();
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.end_run = 1'b1;
        tick();
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.end_run = 1'b0;
        chk_all_zero("midrun_rst");
        tick();
        chk_all_zero("after_rst");
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        set_smp(4'd10, 4'd6, 4'd2, 4'd5, 4'd14, 4'd12);
        tick();
        clr_smp();
        tick();
        chk("clean_pass_cnt", 32'(bus.pass_cnt), 32'd1);
        chk("clean_fail_cnt", 32'(bus.fail_cnt), 32'd0);
        chk("clean_err",      32'(bus.err),      32'd0);
        bus.end_run = 1'b1; tick(); bus.end_run = 1'b0;
        tick();
        chk("clean_done", 32'(bus.done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
